// File: rtl/switch_bank_reader_pkg.sv
// switch_pkg: shared definitions for the switch bank reader.
//   SW_WIDTH / DEFAULT_TICK_DIV : board defaults (10 switches, 1 ms tick at 50 MHz)
//   db_state_t                  : per-bit debounce state (STABLE / DIFFERING)
//   sw_evt_t                    : event word {overrun, fall, rise} at board width
//   clog2()                     : constant-elaboration ceiling log2
package switch_pkg;

    localparam int SW_WIDTH         = 10;
    localparam int DEFAULT_TICK_DIV = 50000;

    typedef enum logic {
        DB_STABLE    = 1'b0,
        DB_DIFFERING = 1'b1
    } db_state_t;

    typedef struct packed {
        logic                overrun;
        logic [SW_WIDTH-1:0] fall;
        logic [SW_WIDTH-1:0] rise;
    } sw_evt_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/switch_bank_reader_debounce_bit.sv
// debounce_bit: synchroniser, debounce counter and stable flop for one switch.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_raw        : asynchronous switch pin
//   i_tick       : one-cycle debounce tick from the shared prescaler
//   o_stable     : debounced switch level
//   o_state      : debounce FSM state (STABLE / DIFFERING), for observation
module debounce_bit
    import switch_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 10
) (
    input  logic      i_clk,
    input  logic      i_rst,
    input  logic      i_raw,
    input  logic      i_tick,
    output logic      o_stable,
    output db_state_t o_state
);

    // Counter only ever reaches DEBOUNCE_TICKS-1, so clog2 bits suffice (min 1).
    localparam int CW = (clog2(DEBOUNCE_TICKS) < 1) ? 1 : clog2(DEBOUNCE_TICKS);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

    logic      r_meta;
    logic      r_sync;
    logic      r_stable;
    logic      w_stable_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    db_state_t r_state;
    db_state_t w_state_next;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
            r_state  <= DB_STABLE;
        end else begin
            r_meta   <= i_raw;
            r_sync   <= r_meta;
            r_stable <= w_stable_next;
            r_cnt    <= w_cnt_next;
            r_state  <= w_state_next;
        end
    end

    // Any cycle where the synchronised input agrees with the stable level
    // restarts the count, so only an unbroken run of differing ticks flips it.
    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_stable_next = r_stable;
        if (r_sync == r_stable) begin
            w_state_next = DB_STABLE;
            w_cnt_next   = '0;
        end else if (i_tick) begin
            if (r_cnt == CNT_LAST) begin
                w_stable_next = r_sync;
                w_cnt_next    = '0;
                w_state_next  = DB_STABLE;
            end else begin
                w_cnt_next   = r_cnt + CW'(1);
                w_state_next = DB_DIFFERING;
            end
        end else begin
            w_state_next = DB_DIFFERING;
        end
    end

    assign o_stable = r_stable;
    assign o_state  = r_state;

endmodule

// File: rtl/switch_bank_reader.sv
// switch_bank_reader: debounces WIDTH slide switches and reports changes as
// rise/fall event words.
// Ports:
//   CLK, RST       : clock, synchronous active-high reset
//   sw_raw         : asynchronous switch pins
//   sw_state       : debounced stable switch state
//   evt_valid      : event pending
//   evt_ready      : consumer accepts the event
//   evt_rise/fall  : bits that rose/fell since the last accepted event
//   evt_overrun    : some bit toggled more than once while the event was pending
//   dbg_differing  : per-bit debounce state (1 = DIFFERING)
//   sw_pos         : (SWITCH_POSITION_EN only) highest set switch index + 1
// Handshake: an event transfers on a posedge with evt_valid && evt_ready;
// evt_ready is ignored while evt_valid is low; until transfer the event word
// only changes by OR-merging new changes into it.
// Optional feature macro: SWITCH_POSITION_EN.
module switch_bank_reader
    import switch_pkg::*;
#(
    parameter int WIDTH          = SW_WIDTH,
    parameter int TICK_DIV       = DEFAULT_TICK_DIV,
    parameter int DEBOUNCE_TICKS = 10
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_state,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [WIDTH-1:0] evt_rise,
    output logic [WIDTH-1:0] evt_fall,
    output logic             evt_overrun,
    output logic [WIDTH-1:0] dbg_differing
`ifdef SWITCH_POSITION_EN
    ,
    output logic [clog2(WIDTH):0] sw_pos
`endif
);

    localparam int PW = clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]    r_pre;
    logic             w_tick;
    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] w_rise_now;
    logic [WIDTH-1:0] w_fall_now;
    logic [WIDTH-1:0] w_merge_rise;
    logic [WIDTH-1:0] w_merge_fall;
    logic             w_change;
    logic             w_repeat;
    logic             r_valid;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic             r_ovr;

    assign w_tick = (r_pre == PRE_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + PW'(1);
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        db_state_t w_st;
        debounce_bit #(
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
        ) u_db (
            .i_clk   (CLK),
            .i_rst   (RST),
            .i_raw   (sw_raw[g]),
            .i_tick  (w_tick),
            .o_stable(w_stable[g]),
            .o_state (w_st)
        );
        assign dbg_differing[g] = (w_st == DB_DIFFERING);
    end

    // r_prev trails sw_state by one cycle, so a change is seen in the cycle
    // sw_state updates and lands in the event registers on the next edge.
    assign w_rise_now   = w_stable & ~r_prev;
    assign w_fall_now   = ~w_stable & r_prev;
    assign w_change     = |(w_rise_now | w_fall_now);
    assign w_merge_rise = r_rise | w_rise_now;
    assign w_merge_fall = r_fall | w_fall_now;
    assign w_repeat     = (|(w_merge_rise & w_merge_fall)) |
                          (|(r_rise & w_rise_now)) |
                          (|(r_fall & w_fall_now));

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_prev  <= '0;
            r_valid <= 1'b0;
            r_rise  <= '0;
            r_fall  <= '0;
            r_ovr   <= 1'b0;
        end else begin
            r_prev <= w_stable;
            if (!r_valid || evt_ready) begin
                // Slot is free or being emptied: a simultaneous change replaces it.
                if (w_change) begin
                    r_valid <= 1'b1;
                    r_rise  <= w_rise_now;
                    r_fall  <= w_fall_now;
                end else begin
                    r_valid <= 1'b0;
                    r_rise  <= '0;
                    r_fall  <= '0;
                end
                r_ovr <= 1'b0;
            end else if (w_change) begin
                r_rise <= w_merge_rise;
                r_fall <= w_merge_fall;
                r_ovr  <= r_ovr | w_repeat;
            end
        end
    end

    assign sw_state    = w_stable;
    assign evt_valid   = r_valid;
    assign evt_rise    = r_rise;
    assign evt_fall    = r_fall;
    assign evt_overrun = r_ovr;

`ifdef SWITCH_POSITION_EN
    localparam int POSW = clog2(WIDTH) + 1;
    logic [POSW-1:0] w_pos;
    logic [POSW-1:0] r_pos;

    always_comb begin
        w_pos = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (w_stable[i]) begin
                w_pos = POSW'(i + 1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pos <= '0;
        end else begin
            r_pos <= w_pos;
        end
    end

    assign sw_pos = r_pos;
`endif

endmodule

// File: tb/tb_switch_bank_reader.sv
// Testbench for switch_bank_reader with TICK_DIV=4, DEBOUNCE_TICKS=3.
// A reference model advances on every posedge from the behavioural rules;
// a compare process checks all outputs against it on every negedge; the
// directed sequence pins literal values; a random phase follows.
module tb_switch_bank_reader;

    localparam int W  = 10;
    localparam int TD = 4;
    localparam int DT = 3;

    logic         CLK = 1'b0;
    logic         RST;
    logic [W-1:0] sw_raw;
    logic [W-1:0] sw_state;
    logic         evt_valid;
    logic         evt_ready;
    logic [W-1:0] evt_rise;
    logic [W-1:0] evt_fall;
    logic         evt_overrun;
    logic [W-1:0] dbg_differing;
`ifdef SWITCH_POSITION_EN
    logic [4:0]   sw_pos;
`endif

    int checks   = 0;
    int failures = 0;

    switch_bank_reader #(
        .WIDTH(W),
        .TICK_DIV(TD),
        .DEBOUNCE_TICKS(DT)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .sw_raw       (sw_raw),
        .sw_state     (sw_state),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_rise     (evt_rise),
        .evt_fall     (evt_fall),
        .evt_overrun  (evt_overrun),
        .dbg_differing(dbg_differing)
`ifdef SWITCH_POSITION_EN
        ,
        .sw_pos       (sw_pos)
`endif
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    logic [W-1:0] m_sync1, m_sync2, m_state, m_prev, m_rise, m_fall, m_diff;
    logic         m_valid, m_ovr, m_init;
    int           m_pre, m_pos;
    int           m_cnt[W];

    initial begin
        m_init = 1'b0;
        forever begin
            @(posedge CLK);
            if (RST) begin
                m_sync1 = '0; m_sync2 = '0; m_state = '0; m_prev = '0;
                m_rise = '0; m_fall = '0; m_diff = '0;
                m_valid = 1'b0; m_ovr = 1'b0; m_pre = 0; m_pos = 0;
                for (int i = 0; i < W; i++) m_cnt[i] = 0;
                m_init = 1'b1;
            end else begin
                logic         tick;
                logic [W-1:0] n_state, n_diff, rn, fn;
                int           p;
                tick    = (m_pre == TD - 1);
                n_state = m_state;
                n_diff  = '0;
                for (int i = 0; i < W; i++) begin
                    if (m_sync2[i] == m_state[i]) begin
                        m_cnt[i] = 0;
                    end else if (tick && m_cnt[i] == DT - 1) begin
                        n_state[i] = m_sync2[i];
                        m_cnt[i]   = 0;
                    end else begin
                        if (tick) m_cnt[i] = m_cnt[i] + 1;
                        n_diff[i] = 1'b1;
                    end
                end
                rn = m_state & ~m_prev;
                fn = ~m_state & m_prev;
                if (!m_valid || evt_ready) begin
                    m_valid = ((rn | fn) != 0);
                    m_rise  = rn;
                    m_fall  = fn;
                    m_ovr   = 1'b0;
                end else if ((rn | fn) != 0) begin
                    if (((m_rise & rn) != 0) || ((m_fall & fn) != 0) ||
                        (((m_rise | rn) & (m_fall | fn)) != 0))
                        m_ovr = 1'b1;
                    m_rise = m_rise | rn;
                    m_fall = m_fall | fn;
                end
                p = 0;
                for (int i = 0; i < W; i++) if (m_state[i]) p = i + 1;
                m_pos   = p;
                m_prev  = m_state;
                m_state = n_state;
                m_diff  = n_diff;
                m_sync2 = m_sync1;
                m_sync1 = sw_raw;
                m_pre   = tick ? 0 : m_pre + 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge CLK);
            if (m_init) begin
                logic bad;
                checks++;
                bad = (sw_state !== m_state) || (evt_valid !== m_valid) ||
                      (evt_rise !== m_rise) || (evt_fall !== m_fall) ||
                      (evt_overrun !== m_ovr) || (dbg_differing !== m_diff);
`ifdef SWITCH_POSITION_EN
                if (sw_pos !== 5'(m_pos)) bad = 1'b1;
`endif
                if (bad) begin
                    failures++;
                    $display("FAIL cycle_compare t=%0t got/exp state %h/%h valid %b/%b rise %h/%h fall %h/%h ovr %b/%b diff %h/%h",
                             $time, sw_state, m_state, evt_valid, m_valid, evt_rise, m_rise,
                             evt_fall, m_fall, evt_overrun, m_ovr, dbg_differing, m_diff);
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_state(input string name, input logic [W-1:0] want, input int budget);
        int n;
        n = 0;
        while (sw_state !== want && n < budget) begin
            @(negedge CLK);
            n++;
        end
        check(name, 32'(sw_state), 32'(want));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int  n;
        int  b;
        logic saw_valid;

        RST = 1'b1;
        sw_raw = '0;
        evt_ready = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset_state", 32'(sw_state), 32'h0);
        check("reset_valid", 32'(evt_valid), 32'h0);
        check("reset_rise", 32'(evt_rise), 32'h0);
        check("reset_ovr", 32'(evt_overrun), 32'h0);
        RST = 1'b0;

        // Single rise on bit 0.
        sw_raw = 10'h001;
        wait_state("rise0_settle", 10'h001, 20);
        @(negedge CLK);
        check("rise0_valid", 32'(evt_valid), 32'h1);
        check("rise0_rise", 32'(evt_rise), 32'h001);
        check("rise0_fall", 32'(evt_fall), 32'h000);

        // Fall of the same bit while the event is held: merge and overrun.
        sw_raw = 10'h000;
        wait_state("fall0_settle", 10'h000, 20);
        @(negedge CLK);
        check("merge_rise", 32'(evt_rise), 32'h001);
        check("merge_fall", 32'(evt_fall), 32'h001);
        check("merge_ovr", 32'(evt_overrun), 32'h1);
        evt_ready = 1'b1;
        @(negedge CLK);
        check("accept_valid", 32'(evt_valid), 32'h0);
        evt_ready = 1'b0;

        // Short glitch on bit 5 must not get through.
        sw_raw = 10'h020;
        repeat (6) @(negedge CLK);
        sw_raw = 10'h000;
        repeat (20) @(negedge CLK);
        check("glitch_state", 32'(sw_state), 32'h0);
        check("glitch_valid", 32'(evt_valid), 32'h0);

        // Two bits settling together give one event.
        sw_raw = 10'h204;
        wait_state("pair_settle", 10'h204, 20);
        @(negedge CLK);
        check("pair_valid", 32'(evt_valid), 32'h1);
        check("pair_rise", 32'(evt_rise), 32'h204);
        check("pair_fall", 32'(evt_fall), 32'h000);

        // Accept on the same edge a new change lands: new event replaces old.
        sw_raw = 10'h200;
        wait_state("swap_settle", 10'h200, 20);
        evt_ready = 1'b1;
        @(negedge CLK);
        check("swap_valid", 32'(evt_valid), 32'h1);
        check("swap_rise", 32'(evt_rise), 32'h000);
        check("swap_fall", 32'(evt_fall), 32'h004);
        check("swap_ovr", 32'(evt_overrun), 32'h0);
        @(negedge CLK);
        check("swap_drain", 32'(evt_valid), 32'h0);
        evt_ready = 1'b0;

        // Reset while bit 7 is two ticks into its debounce.
        sw_raw = 10'h280;
        n = 0;
        while (m_cnt[7] != 2 && n < 40) begin
            @(negedge CLK);
            n++;
        end
        check("mid_debounce_differing", 32'(dbg_differing[7]), 32'h1);
        RST = 1'b1;
        @(negedge CLK);
        check("midrst_state", 32'(sw_state), 32'h0);
        check("midrst_valid", 32'(evt_valid), 32'h0);
        RST = 1'b0;
        n = 0;
        saw_valid = 1'b0;
        while (sw_state !== 10'h280 && n < 30) begin
            @(negedge CLK);
            n++;
            if (evt_valid) saw_valid = 1'b1;
        end
        check("midrst_full_debounce_cycles", 32'(n), 32'd12);
        check("midrst_no_early_event", 32'(saw_valid), 32'h0);
        @(negedge CLK);
        check("midrst_event_rise", 32'(evt_rise), 32'h280);

        // Random phase: slow switch activity, random ready, rare resets.
        for (int c = 0; c < 4000; c++) begin
            @(negedge CLK);
            RST = ($urandom_range(0, 999) == 0);
            evt_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 11) == 0) begin
                b = $urandom_range(0, W - 1);
                sw_raw[b] = ~sw_raw[b];
            end
        end
        RST = 1'b0;
        evt_ready = 1'b1;
        repeat (60) @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
